// File: rtl/uart_rx_if.sv
// Serial receive interface: raw line in, received word and status strobes out.
// The receiver takes the slave side; whatever drives the line and consumes words takes master.
interface uart_rx_if #(
  parameter int DATA_W = 8
);
  logic              rx_in;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              busy;

  modport master (
    output rx_in,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx_in,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: two-flop line synchroniser, mid-bit sampling FSM,
// stop-bit check with a one-cycle word/error strobe and a break-hold state.
module uart_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic     clk,
  input  logic     rst_b,
  uart_rx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;
  logic              sync1;
  logic              rx_s;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.rx_in;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        // Recheck the start bit half a bit later so a short glitch is dropped.
        START: begin
          if (cnt == HALF_LAST) begin
            if (!rx_s) begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            shreg <= {rx_s, shreg[DATA_W-1:1]};
            cnt   <= '0;
            if (idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              bus.rx_data  <= shreg;
              bus.rx_valid <= 1'b1;
              bus.busy     <= 1'b0;
              state        <= IDLE;
            end else begin
              bus.frame_err <= 1'b1;
              state         <= BRK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Held-low line: wait for idle so a break reports only one error.
        BRK: begin
          if (rx_s) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: a frame-level model predicts each strobe's
// cycle, kind and word; monitors pop and compare whenever a DUT strobes or is due to.
module tb_uart_rx;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         cycle;
  } exp_t;

  logic clk;
  logic rst_b;
  logic rx_line;
  logic rx_line5;
  int   cyc;
  int   last_e0;
  int   vectors;
  int   miscompares;
  logic [7:0] last_data;
  logic [7:0] last_data5;
  exp_t exp_q[$];
  exp_t exp5_q[$];

  uart_rx_if #(.DATA_W(8)) bus ();
  uart_rx_if #(.DATA_W(5)) bus5 ();

  assign bus.rx_in  = rx_line;
  assign bus5.rx_in = rx_line5;

  uart_rx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  uart_rx #(.DATA_W(5), .CLKS_PER_BIT(8)) dut5 (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard for the default-parameter receiver.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_b) begin
      last_data = 8'h00;
    end else begin
      if (bus.rx_valid || bus.frame_err || (exp_q.size() > 0 && cyc >= exp_q[0].cycle)) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_strobe", {30'd0, bus.rx_valid, bus.frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("strobe_cycle", cyc, e.cycle);
          check_output("rx_valid", {31'd0, bus.rx_valid}, {31'd0, !e.is_err});
          check_output("frame_err", {31'd0, bus.frame_err}, {31'd0, e.is_err});
          if (!e.is_err) check_output("rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
        end
      end
      check_output("strobe_exclusive", {31'd0, bus.rx_valid & bus.frame_err}, 32'd0);
      if (!bus.rx_valid) check_output("rx_data_stable", {24'd0, bus.rx_data}, {24'd0, last_data});
      last_data = bus.rx_data;
    end
  end

  // Scoreboard for the DATA_W=5, CLKS_PER_BIT=8 receiver.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_b) begin
      last_data5 = 8'h00;
    end else begin
      if (bus5.rx_valid || bus5.frame_err || (exp5_q.size() > 0 && cyc >= exp5_q[0].cycle)) begin
        if (exp5_q.size() == 0) begin
          check_output("unexpected_strobe5", {30'd0, bus5.rx_valid, bus5.frame_err}, 32'd0);
        end else begin
          e = exp5_q.pop_front();
          check_output("strobe_cycle5", cyc, e.cycle);
          check_output("rx_valid5", {31'd0, bus5.rx_valid}, {31'd0, !e.is_err});
          check_output("frame_err5", {31'd0, bus5.frame_err}, {31'd0, e.is_err});
          if (!e.is_err) check_output("rx_data5", {27'd0, bus5.rx_data}, {24'd0, e.data});
        end
      end
      last_data5 = {3'b000, bus5.rx_data};
    end
  end

  task automatic drive_bit(input bit sel, input logic v, input int n);
    @(negedge clk);
    if (sel) rx_line5 = v;
    else rx_line = v;
    repeat (n - 1) @(negedge clk);
  endtask

  // One frame: start, data LSB first, stop, then `gap` idle-high cycles.
  task automatic apply_stimulus(input bit sel, input logic [7:0] data, input logic stop_bit,
                                input int gap, input bit push);
    int   dw;
    int   cpb;
    exp_t e;
    dw  = sel ? 5 : 8;
    cpb = sel ? 8 : 4;
    @(negedge clk);
    if (sel) rx_line5 = 1'b0;
    else rx_line = 1'b0;
    last_e0 = cyc + 1;
    if (push) begin
      e.is_err = !stop_bit;
      e.data   = sel ? {3'b000, data[4:0]} : data;
      e.cycle  = last_e0 + 2 + cpb / 2 + cpb * (dw + 1);
      if (sel) exp5_q.push_back(e);
      else exp_q.push_back(e);
    end
    repeat (cpb - 1) @(negedge clk);
    for (int i = 0; i < dw; i++) drive_bit(sel, data[i], cpb);
    drive_bit(sel, stop_bit, cpb);
    if (gap > 0) drive_bit(sel, 1'b1, gap);
  endtask

  task automatic check_busy_at(input int c, input logic v);
    while (cyc < c) @(negedge clk);
    check_output("busy", {31'd0, bus.busy}, {31'd0, v});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   g0;
    int   r;
    int   wait_cycles;
    logic [7:0] d;
    logic       sb;
    logic [7:0] pattern;

    vectors     = 0;
    miscompares = 0;
    last_e0     = 0;
    rx_line     = 1'b1;
    rx_line5    = 1'b1;
    rst_b       = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check_output("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check_output("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check_output("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] single frame 0xA5");
    fork
      apply_stimulus(1'b0, 8'hA5, 1'b1, 4, 1'b1);
      begin
        @(negedge clk);
        #1;
        check_busy_at(last_e0 + 1, 1'b0);
        check_busy_at(last_e0 + 2, 1'b1);
        check_busy_at(last_e0 + 39, 1'b1);
        check_busy_at(last_e0 + 40, 1'b0);
      end
    join
    check_output("hold_A5", {24'd0, bus.rx_data}, 32'hA5);

    $display("[TB] back-to-back 0x00, 0xFF");
    apply_stimulus(1'b0, 8'h00, 1'b1, 0, 1'b1);
    apply_stimulus(1'b0, 8'hFF, 1'b1, 6, 1'b1);

    $display("[TB] one-cycle glitch");
    @(negedge clk);
    rx_line = 1'b0;
    g0 = cyc + 1;
    @(negedge clk);
    rx_line = 1'b1;
    check_busy_at(g0 + 3, 1'b1);
    check_busy_at(g0 + 4, 1'b0);
    repeat (10) @(negedge clk);
    check_output("glitch_hold", {24'd0, bus.rx_data}, 32'hFF);

    $display("[TB] bad stop bit then held-low break");
    apply_stimulus(1'b0, 8'h3C, 1'b0, 0, 1'b1);
    drive_bit(1'b0, 1'b0, 100);
    check_output("break_busy", {31'd0, bus.busy}, 32'd1);
    check_output("break_hold", {24'd0, bus.rx_data}, 32'hFF);
    @(negedge clk);
    rx_line = 1'b1;
    r = cyc + 1;
    check_busy_at(r + 1, 1'b1);
    check_busy_at(r + 2, 1'b0);
    repeat (4) @(negedge clk);

    $display("[TB] reset mid-frame");
    pattern = 8'h5A;
    drive_bit(1'b0, 1'b0, 4);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, pattern[i], 4);
    @(negedge clk);
    rx_line = pattern[3];
    #2;
    rst_b = 1'b0;
    #1;
    check_output("midreset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check_output("midreset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check_output("midreset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check_output("midreset_busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    for (int i = 4; i < 8; i++) drive_bit(1'b0, pattern[i], 4);
    drive_bit(1'b0, 1'b1, 8);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    apply_stimulus(1'b0, 8'h81, 1'b1, 4, 1'b1);

    $display("[TB] random frames");
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      apply_stimulus(1'b0, d, sb, sb ? $urandom_range(0, 6) : $urandom_range(1, 6), 1'b1);
    end

    $display("[TB] non-default parameters");
    apply_stimulus(1'b1, 8'h13, 1'b1, 3, 1'b1);
    for (int n = 0; n < 6; n++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      apply_stimulus(1'b1, d, sb, sb ? $urandom_range(0, 10) : $urandom_range(1, 10), 1'b1);
    end

    wait_cycles = 0;
    while ((exp_q.size() > 0 || exp5_q.size() > 0) && wait_cycles < 200) begin
      @(negedge clk);
      wait_cycles++;
    end
    repeat (2) @(negedge clk);
    check_output("drain", exp_q.size(), 32'd0);
    check_output("drain5", exp5_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
